lcd_text_sequencer: RTL and testbench
=====================================

Name: lcd_text_sequencer

Overview:
- Upstream command/data source for the LCD write-cycle controller.
- Runs the HD44780 power-up init list, then refreshes a 2x16 character display forever from a 32-byte character buffer.
- Issues one byte per handshake (odata/ors plus a one-cycle ostart) and waits for the controller's done before the next byte.
- The host updates characters through a simple write port; no host flow control is needed.

Parameters:
PWR_DLY, 1000000, power-up wait in iclk cycles before the first command (20 ms at 50 MHz).
CMD_DLY, 2500, post-done wait for ordinary commands and data (50 us at 50 MHz).
CLR_DLY, 82000, post-done wait after the clear command 0x01 (1.64 ms at 50 MHz).

Ports:
iclk  in  1  clock.
irst_n  in  1  asynchronous active-low reset.
iwr  in  1  host buffer write strobe, one byte per cycle.
iaddr  in  5  buffer address; 0-15 is line 1, 16-31 is line 2.
ichar  in  8  character code to write.
odata  out  8  byte to the controller.
ors  out  1  register select to the controller; 0 = command, 1 = data.
ostart  out  1  start pulse to the controller.
idone  in  1  done from the controller; level, cleared by the controller after each start.
oinit_done  out  1  high once the init list has completed.
oframe  out  1  one-cycle pulse after the last character of each refresh frame.

Behaviour:
- Reset (async, irst_n=0):
  - odata=8'h00, ors=0, ostart=0, oinit_done=0, oframe=0.
  - Sequence index idx=0, delay counter cleared, FSM=PWRUP.
  - All 32 buffer entries reset to 8'h20 (space).
- Reset mid-operation aborts everything immediately. After release, the block restarts from PWRUP with the full power-up delay.
- Buffer write: when iwr=1, buf[iaddr]<=ichar on the rising edge. This is legal in any state.
- Sequence table (idx is 6 bits):
  - idx 0 = 0x38, rs=0.
  - idx 1 = 0x0C, rs=0.
  - idx 2 = 0x01, rs=0.
  - idx 3 = 0x06, rs=0.
  - idx 4 = 0x80, rs=0.
  - idx 5..20 = buf[idx-5], rs=1.
  - idx 21 = 0xC0, rs=0.
  - idx 22..37 = buf[idx-6], rs=1.
  - After idx 37, idx wraps to 4, not 0. Init runs exactly once per reset.
- FSM:
  - PWRUP: count PWR_DLY cycles, then go to ISSUE.
  - ISSUE (1 cycle): register odata/ors from table[idx]. ostart=1 in the following cycle only, then go to WAIT.
    - odata/ors stay stable from that registration until they are re-registered in the next ISSUE.
    - ostart is never high for more than one consecutive cycle.
  - WAIT: wait for a rising edge of idone (idone=1 and its registered previous value=0). A stale idone=1 left over from the previous byte does not count. Then go to DLY.
  - DLY: count CMD_DLY cycles, or CLR_DLY if the byte was command 0x01 with rs=0. Then go to NEXT.
  - NEXT (1 cycle):
    - If idx==3, set oinit_done=1; it holds until reset.
    - If idx==37, pulse oframe=1 for this cycle.
    - Advance idx with the wrap rule above, then go to ISSUE.
- Buffer reads happen in ISSUE. A host write to the same address in the same cycle is not seen: the old value is issued and the new value appears on the next frame.
- Delay counters are 20 bits. A delay parameter of 0 behaves as 1 cycle.
- No timeout: if idone never rises, the FSM stays in WAIT. The verification engineer must treat this as a hang, not a defect of this block.
- Per-byte period = (start-to-done latency of the controller) + CMD_DLY + 3 overhead cycles.

Test Plan:
Benches use PWR_DLY=100, CMD_DLY=10, CLR_DLY=40, with the LCD write-cycle controller instantiated downstream.
1. Release reset, no host writes -> first ostart 101-102 cycles after reset release. Bytes 38,0C,01,06 with ors=0, then oinit_done=1, then 80, sixteen 20s with ors=1, C0, sixteen 20s.
2. Gap measurement -> the gap after the 0x01 done is 40 cycles; gaps after all other dones are 10 cycles.
3. Before init, write iaddr=0 "H" (0x48) and iaddr=16 "i" (0x69) -> the byte after 0x80 is 0x48 and the byte after 0xC0 is 0x69.
4. After the frame end, sequence resumes at 0x80 (not 0x38) and oframe pulses exactly once per frame. A write to iaddr=5 in the same cycle that idx=10 is in ISSUE issues the old char; the next frame issues the new one.
5. Hold idone low in WAIT (controller disconnected) -> no further ostart. Assert reset mid-WAIT -> outputs clear immediately, restart from PWRUP, buffer reads 0x20.
6. Force idone=1 continuously -> FSM does not advance past WAIT after the first byte, because no rising edge occurs.

Source files
------------

// File: rtl/lcd_text_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_text_sequencer
//
// Feeds the LCD write-cycle controller. After a power-up wait it sends the
// HD44780 init list (0x38, 0x0C, 0x01, 0x06) once, then refreshes a 2x16
// display forever from a 32-byte character buffer:
//   0x80, line-1 chars (buf[0..15]), 0xC0, line-2 chars (buf[16..31]), repeat.
//
// Handshake with the controller: odata/ors are registered in the ISSUE cycle
// and stay stable until the next ISSUE; ostart is high for exactly the one
// cycle after ISSUE; the byte is complete on a rising edge of idone (a level
// the controller clears after each start), so a stale idone=1 never counts.
//
// Ports:
//   iclk, irst_n      clock, asynchronous active-low reset
//   iwr/iaddr/ichar   host buffer write (0-15 line 1, 16-31 line 2)
//   odata/ors/ostart  byte, register select (1 = data), start pulse
//   idone             done level from the controller
//   oinit_done        high once the init list has completed
//   oframe            one-cycle pulse after the last char of each frame
//   odbg_state        current FSM state, for observation only
// -----------------------------------------------------------------------------
module lcd_text_sequencer #(
   parameter int unsigned PWR_DLY = 1000000,
   parameter int unsigned CMD_DLY = 2500,
   parameter int unsigned CLR_DLY = 82000
) (
   input  logic       iclk,
   input  logic       irst_n,
   input  logic       iwr,
   input  logic [4:0] iaddr,
   input  logic [7:0] ichar,
   output logic [7:0] odata,
   output logic       ors,
   output logic       ostart,
   input  logic       idone,
   output logic       oinit_done,
   output logic       oframe,
   output logic [2:0] odbg_state
);

   typedef enum logic [2:0] {
      S_PWRUP = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_DLY   = 3'd3,
      S_NEXT  = 3'd4
   } state_t;

   // A delay of 0 behaves as a 1-cycle delay.
   localparam int unsigned PWR_N = (PWR_DLY == 0) ? 1 : PWR_DLY;
   localparam int unsigned CMD_N = (CMD_DLY == 0) ? 1 : CMD_DLY;
   localparam int unsigned CLR_N = (CLR_DLY == 0) ? 1 : CLR_DLY;
   localparam logic [19:0] PWR_LAST = 20'(PWR_N - 1);
   localparam logic [19:0] CMD_LAST = 20'(CMD_N - 1);
   localparam logic [19:0] CLR_LAST = 20'(CLR_N - 1);

   state_t      state_q, state_d;
   logic [19:0] cnt_q, cnt_d;
   logic [5:0]  idx_q, idx_d;
   logic [7:0]  odata_q, odata_d;
   logic        ors_q, ors_d;
   logic        ostart_q, ostart_d;
   logic        init_done_q, init_done_d;
   logic        idone_q;
   logic [7:0]  cbuf_q [32];

   logic [4:0]  rd_addr;
   logic [7:0]  tbl_data;
   logic        tbl_rs;
   logic [19:0] dly_last;

   // Character buffer: host writes are accepted in every state.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         for (int i = 0; i < 32; i++) cbuf_q[i] <= 8'h20;
      end else if (iwr) begin
         cbuf_q[iaddr] <= ichar;
      end
   end

   // Sequence table lookup for the current index.
   always_comb begin
      tbl_data = 8'h00;
      tbl_rs   = 1'b0;
      rd_addr  = 5'd0;
      case (idx_q)
         6'd0:  tbl_data = 8'h38;
         6'd1:  tbl_data = 8'h0C;
         6'd2:  tbl_data = 8'h01;
         6'd3:  tbl_data = 8'h06;
         6'd4:  tbl_data = 8'h80;
         6'd21: tbl_data = 8'hC0;
         default: begin
            if (idx_q >= 6'd5 && idx_q <= 6'd20) begin
               rd_addr  = 5'(idx_q - 6'd5);
               tbl_data = cbuf_q[rd_addr];
               tbl_rs   = 1'b1;
            end else if (idx_q >= 6'd22 && idx_q <= 6'd37) begin
               rd_addr  = 5'(idx_q - 6'd6);
               tbl_data = cbuf_q[rd_addr];
               tbl_rs   = 1'b1;
            end
         end
      endcase
   end

   // The clear command needs the long settle time.
   assign dly_last = (odata_q == 8'h01 && !ors_q) ? CLR_LAST : CMD_LAST;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      odata_d     = odata_q;
      ors_d       = ors_q;
      ostart_d    = 1'b0;
      init_done_d = init_done_q;
      case (state_q)
         S_PWRUP: begin
            if (cnt_q == PWR_LAST) begin
               cnt_d   = 20'd0;
               state_d = S_ISSUE;
            end else begin
               cnt_d = cnt_q + 20'd1;
            end
         end
         S_ISSUE: begin
            odata_d  = tbl_data;
            ors_d    = tbl_rs;
            ostart_d = 1'b1;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (idone && !idone_q) state_d = S_DLY;
         end
         S_DLY: begin
            if (cnt_q == dly_last) begin
               cnt_d   = 20'd0;
               state_d = S_NEXT;
            end else begin
               cnt_d = cnt_q + 20'd1;
            end
         end
         S_NEXT: begin
            if (idx_q == 6'd3) init_done_d = 1'b1;
            // Refresh loops back to the line-1 address command, never to init.
            idx_d   = (idx_q == 6'd37) ? 6'd4 : idx_q + 6'd1;
            state_d = S_ISSUE;
         end
         default: state_d = S_PWRUP;
      endcase
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q     <= S_PWRUP;
         cnt_q       <= 20'd0;
         idx_q       <= 6'd0;
         odata_q     <= 8'h00;
         ors_q       <= 1'b0;
         ostart_q    <= 1'b0;
         init_done_q <= 1'b0;
         idone_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         odata_q     <= odata_d;
         ors_q       <= ors_d;
         ostart_q    <= ostart_d;
         init_done_q <= init_done_d;
         idone_q     <= idone;
      end
   end

   assign odata      = odata_q;
   assign ors        = ors_q;
   assign ostart     = ostart_q;
   assign oinit_done = init_done_q;
   assign oframe     = (state_q == S_NEXT) && (idx_q == 6'd37);
   assign odbg_state = state_q;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for lcd_text_sequencer. A behavioural controller model answers each
// ostart with idone after a random latency; a reference model derives each
// expected byte from its position in the stream and a shadow copy of the
// character buffer.
// -----------------------------------------------------------------------------
module tb_lcd_text_sequencer;

   localparam int PWR = 100;
   localparam int CMD = 10;
   localparam int CLR = 40;

   // ---------------- clock / reset ----------------
   logic       iclk = 1'b0;
   logic       irst_n;
   logic       iwr;
   logic [4:0] iaddr;
   logic [7:0] ichar;
   logic [7:0] odata;
   logic       ors;
   logic       ostart;
   logic       idone;
   logic       oinit_done;
   logic       oframe;
   logic [2:0] odbg_state;

   always #5 iclk = ~iclk;

   lcd_text_sequencer #(.PWR_DLY(PWR), .CMD_DLY(CMD), .CLR_DLY(CLR)) dut (
      .iclk(iclk), .irst_n(irst_n), .iwr(iwr), .iaddr(iaddr), .ichar(ichar),
      .odata(odata), .ors(ors), .ostart(ostart), .idone(idone),
      .oinit_done(oinit_done), .oframe(oframe), .odbg_state(odbg_state)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int since_rel = 0;
   int n_start = 0;
   int n_rise = 0;
   int n_frames = 0;
   int rise_cyc = 0;
   int lat_left = 0;
   int wr_sched = -1;
   int prev_dly = 0;
   int viol = 0;
   int ctrl_mode = 0;   // 0 normal, 1 disconnected (idone low), 2 idone stuck high
   bit pre_en = 0;
   bit dir_en = 0;
   bit rand_en = 0;
   logic [8:0] prev_out = '0;
   logic       prev_ostart = 0;
   logic       prev_oframe = 0;
   logic [8:0] exp_q [$];
   logic [8:0] exp_v;
   logic [8:0] got_v;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Shadow buffer; ref_prev is the content as it stood during the previous
   // cycle, which is what a byte issued in that cycle must reflect.
   logic [7:0] ref_buf  [32];
   logic [7:0] ref_prev [32];

   always @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         for (int i = 0; i < 32; i++) begin
            ref_buf[i]  <= 8'h20;
            ref_prev[i] <= 8'h20;
         end
      end else begin
         ref_prev <= ref_buf;
         if (iwr) ref_buf[iaddr] <= ichar;
      end
   end

   // Expected {rs, data} for the p-th byte since reset.
   function automatic logic [8:0] exp_byte(input int p);
      int j;
      if (p == 0) return {1'b0, 8'h38};
      if (p == 1) return {1'b0, 8'h0C};
      if (p == 2) return {1'b0, 8'h01};
      if (p == 3) return {1'b0, 8'h06};
      j = (p - 4) % 34;
      if (j == 0)  return {1'b0, 8'h80};
      if (j <= 16) return {1'b1, ref_prev[j-1]};
      if (j == 17) return {1'b0, 8'hC0};
      return {1'b1, ref_prev[j-2]};
   endfunction

   // ---------------- monitor, scoreboard, controller and host drivers ----------------
   initial begin
      idone = 1'b0;
      iwr   = 1'b0;
      iaddr = '0;
      ichar = '0;
      forever begin
         @(negedge iclk);
         cyc++;
         if (!irst_n) begin
            n_start = 0; n_rise = 0; n_frames = 0; lat_left = 0; since_rel = 0;
            prev_out = '0; prev_ostart = 0; prev_oframe = 0; wr_sched = -1;
            idone = (ctrl_mode == 2);
            iwr = 1'b0;
         end else begin
            since_rel++;
            if (ostart && prev_ostart) viol++;
            if (oframe && prev_oframe) viol++;
            if ({ors, odata} != prev_out && !ostart) viol++;
            if (oframe) begin
               n_frames++;
               check("oframe_position", (n_start >= 38 && (n_start - 4) % 34 == 0), 1);
            end
            if (ostart) begin
               exp_q.push_back(exp_byte(n_start));
               got_v = {ors, odata};
               exp_v = exp_q.pop_front();
               check($sformatf("byte_%0d", n_start), got_v, exp_v);
               check("init_done", oinit_done, (n_start >= 4));
               if (n_start == 0)
                  check("first_start_101_102", (since_rel >= 101 && since_rel <= 102), 1);
               else if (ctrl_mode != 2)
                  check("gap_after_done", cyc - rise_cyc, prev_dly + 3);
               if (n_start >= 38 && (n_start - 4) % 34 == 0)
                  check("frames_before_80", n_frames, (n_start - 4) / 34);
               prev_dly = (exp_v == {1'b0, 8'h01}) ? CLR : CMD;
               n_start++;
            end
            prev_ostart = ostart;
            prev_oframe = oframe;
            prev_out    = {ors, odata};

            // controller model
            case (ctrl_mode)
               0: begin
                  if (ostart) begin
                     idone    = 1'b0;
                     lat_left = $urandom_range(1, 5);
                  end else if (lat_left > 0) begin
                     lat_left--;
                     if (lat_left == 0) begin
                        idone    = 1'b1;
                        rise_cyc = cyc;
                        n_rise++;
                        // Lands a write to buf[5] in the ISSUE cycle of idx 10.
                        if (dir_en && n_rise == 10) wr_sched = cyc + CMD + 2;
                     end
                  end
               end
               1: begin
                  if (ostart) idone = 1'b0;
                  lat_left = 0;
               end
               default: idone = 1'b1;
            endcase

            // host writes
            iwr = 1'b0;
            if (cyc == wr_sched) begin
               iwr = 1'b1; iaddr = 5'd5; ichar = 8'h7E;
            end else if (pre_en && since_rel == 5) begin
               iwr = 1'b1; iaddr = 5'd0; ichar = 8'h48;
            end else if (pre_en && since_rel == 6) begin
               iwr = 1'b1; iaddr = 5'd16; ichar = 8'h69;
            end else if (rand_en && $urandom_range(0, 7) == 0) begin
               iwr   = 1'b1;
               iaddr = 5'($urandom_range(0, 31));
               ichar = 8'($urandom_range(32, 126));
            end
         end
      end
   end

   task automatic wait_starts(input int target, input int budget, input string tag);
      for (int i = 0; i < budget && n_start < target; i++) begin
         @(negedge iclk);
         #1;
      end
      check(tag, (n_start >= target), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_odata"}, odata, 8'h00);
      check({tag, "_ors"}, ors, 1'b0);
      check({tag, "_ostart"}, ostart, 1'b0);
      check({tag, "_init_done"}, oinit_done, 1'b0);
      check({tag, "_oframe"}, oframe, 1'b0);
   endtask

   // ---------------- main sequence ----------------
   int s0;
   initial begin
      irst_n = 1'b0;
      ctrl_mode = 0;
      pre_en = 1; dir_en = 1; rand_en = 0;
      repeat (3) @(negedge iclk);
      #1;
      check_reset_outputs("reset");

      // Normal run: init, H/i written during power-up, three frames.
      @(negedge iclk); #2 irst_n = 1'b1;
      wait_starts(39, 4000, "reach_frame2");
      rand_en = 1;
      wait_starts(4 + 34 * 3 + 1, 8000, "reach_frame4");

      // Controller disconnected: FSM must sit in WAIT with no new start.
      rand_en = 0; pre_en = 0; dir_en = 0;
      ctrl_mode = 1;
      repeat (100) @(negedge iclk);
      #1 s0 = n_start;
      repeat (300) @(negedge iclk);
      #1 check("no_start_while_disconnected", n_start, s0);

      // Reset in the middle of WAIT clears outputs at once.
      @(negedge iclk); #2 irst_n = 1'b0;
      #1 check_reset_outputs("mid_wait_reset");
      repeat (3) @(negedge iclk);
      ctrl_mode = 0;
      #2 irst_n = 1'b1;
      wait_starts(4 + 34 + 2, 3000, "reach_after_reset");

      // idone stuck high: only the first byte may be started.
      @(negedge iclk); #2 irst_n = 1'b0;
      ctrl_mode = 2;
      repeat (3) @(negedge iclk);
      #2 irst_n = 1'b1;
      wait_starts(1, 300, "stuck_first_start");
      repeat (300) @(negedge iclk);
      #1 check("stuck_idone_single_start", n_start, 1);

      check("protocol_violations", viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
